// File: rtl/striping_pkg.sv
// striping_pkg: declarations shared by the striping / un_striping pair.
//   DEF_WIDTH / DEF_DEPTH : default word width and per-lane FIFO depth
//   PTR_W                 : FIFO pointer width for the default depth
//   lane_t                : lane selector (LANE0 / LANE1)
package striping_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;
    localparam int PTR_W     = $clog2(DEF_DEPTH);

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_t;

endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: small synchronous FIFO that absorbs skew on one striped lane.
//   clk_2f   : clock, rising edge
//   reset    : asynchronous, active-high; empties the FIFO
//   push/din : write strobe and word
//   pop      : read strobe; ignored when empty
//   dout     : head word, combinational from storage
//   empty    : no words held
//   full     : DEPTH words held
//   overflow : one-cycle pulse, a pushed word was dropped this edge
module lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign dout  = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot in the same edge, so the push is kept.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only visible through a non-empty head.
    always_ff @(posedge clk_2f) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/un_striping.sv
// un_striping: merges two striped lanes into one word stream, lane 0 first,
// strict round-robin. Each lane is buffered in a lane_fifo; the selector only
// ever pops the lane whose turn it is, and waits when that lane is empty.
//   clk_2f, reset        : clock and asynchronous active-high reset
//   lane_0/valid_0       : lane 0 word and one-cycle strobe
//   lane_1/valid_1       : lane 1 word and one-cycle strobe
//   data_out/valid_out   : registered merged word and its strobe
//   err_overflow         : sticky, a lane word was dropped on a full FIFO
module un_striping
    import striping_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] lane_0,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] lane_1,
    input  logic             valid_1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             err_overflow
);

    lane_t            exp_q, exp_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] dout0, dout1, head;
    logic             empty0, empty1, full0, full1, ovf0, ovf1;
    logic             avail, pop0, pop1;

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .push     (valid_0),
        .din      (lane_0),
        .pop      (pop0),
        .dout     (dout0),
        .empty    (empty0),
        .full     (full0),
        .overflow (ovf0)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .push     (valid_1),
        .din      (lane_1),
        .pop      (pop1),
        .dout     (dout1),
        .empty    (empty1),
        .full     (full1),
        .overflow (ovf1)
    );

    // Only the expected lane is considered; the other lane is never drained early.
    assign avail = (exp_q == LANE0) ? ~empty0 : ~empty1;
    assign head  = (exp_q == LANE0) ? dout0 : dout1;
    assign pop0  = avail & (exp_q == LANE0);
    assign pop1  = avail & (exp_q == LANE1);

    always_comb begin
        exp_d   = exp_q;
        data_d  = data_q;
        valid_d = avail;
        err_d   = err_q | ovf0 | ovf1;
        if (avail) begin
            data_d = head;
            exp_d  = (exp_q == LANE0) ? LANE1 : LANE0;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            exp_q   <= LANE0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            exp_q   <= exp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign err_overflow = err_q;

    // full flags are consumed inside the FIFOs; kept visible for debug.
    logic unused_full;
    assign unused_full = full0 ^ full1;

endmodule

// File: tb/tb_un_striping.sv
module tb_un_striping;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk_2f = 1'b0;
  logic             reset  = 1'b1;
  logic [WIDTH-1:0] lane_0 = '0, lane_1 = '0;
  logic             valid_0 = 1'b0, valid_1 = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             valid_out, err_overflow;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q0[$], q1[$];
  bit               mexp;
  logic [WIDTH-1:0] mdata;
  bit               mvalid, merr;

  un_striping #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_2f       (clk_2f),
    .reset        (reset),
    .lane_0       (lane_0),
    .valid_0      (valid_0),
    .lane_1       (lane_1),
    .valid_1      (valid_1),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .err_overflow (err_overflow)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    mexp   = 0;
    mdata  = '0;
    mvalid = 0;
    merr   = 0;
  endtask

  task automatic model_step();
    mvalid = mexp ? (q1.size() > 0) : (q0.size() > 0);
    if (mvalid) begin
      mdata = mexp ? q1.pop_front() : q0.pop_front();
      mexp  = ~mexp;
    end
    if (valid_0) begin
      if (q0.size() < DEPTH) q0.push_back(lane_0);
      else merr = 1;
    end
    if (valid_1) begin
      if (q1.size() < DEPTH) q1.push_back(lane_1);
      else merr = 1;
    end
  endtask

  task automatic drive(input bit v0, input logic [WIDTH-1:0] d0,
                       input bit v1, input logic [WIDTH-1:0] d1);
    valid_0 = v0; lane_0 = d0;
    valid_1 = v1; lane_1 = d1;
    @(posedge clk_2f);
    model_step();
    #1;
    valid_0 = 0; valid_1 = 0;
  endtask

  task automatic do_reset();
    valid_0 = 0; valid_1 = 0;
    reset = 1;
    @(posedge clk_2f);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    drive(1, 32'h1234_5678, 0, '0);
    drive(0, '0, 0, '0);
    #2 reset = 1;
    #1;
    model_reset();
    checks++;
    if ({valid_out, err_overflow, data_out} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_async: got v=%b e=%b d=%h want 0 0 0", valid_out, err_overflow, data_out);
    end
    @(negedge clk_2f);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 0, '0);
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: valid_out=%b want 0", i, valid_out);
      end
    end
  endtask

  task automatic test_no_skew();
    logic [WIDTH-1:0] w[4];
    logic [WIDTH-1:0] got;
    w[0] = 32'hFFFF_FFFF; w[1] = 32'hEEEE_EEEE;
    w[2] = 32'hDDDD_DDDD; w[3] = 32'hCCCC_CCCC;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(i % 2 == 0, w[i], i % 2 == 1, w[i]);
      else       drive(0, '0, 0, '0);
      if (i >= 1) begin
        got = w[i-1];
        checks++;
        if (valid_out !== 1'b1 || data_out !== got) begin
          errors++;
          $display("FAIL no_skew edge%0d: got v=%b d=%h want 1 %h", i, valid_out, data_out, got);
        end
      end
    end
  endtask

  task automatic test_skew();
    do_reset();
    drive(0, '0, 1, 32'h0000_0002);
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) drive(1, 32'h0000_0001, 0, '0);
      else        drive(0, '0, 0, '0);
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL skew_wait edge%0d: valid_out=%b want 0", i, valid_out);
      end
    end
    drive(0, '0, 0, '0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h0000_0001) begin
      errors++;
      $display("FAIL skew_first: got v=%b d=%h want 1 00000001", valid_out, data_out);
    end
    drive(0, '0, 0, '0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL skew_second: got v=%b d=%h want 1 00000002", valid_out, data_out);
    end
  endtask

  task automatic test_gap();
    do_reset();
    drive(1, 32'h0000_0010, 1, 32'h0000_0020);
    drive(0, '0, 1, 32'h0000_0004);
    drive(0, '0, 0, '0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h0000_0020) begin
      errors++;
      $display("FAIL gap_l1pop: got v=%b d=%h want 1 00000020", valid_out, data_out);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, '0, 0, '0);
      checks++;
      if (valid_out !== 1'b0 || data_out !== 32'h0000_0020) begin
        errors++;
        $display("FAIL gap_hold cyc%0d: got v=%b d=%h want 0 00000020", i, valid_out, data_out);
      end
    end
    drive(1, 32'h0000_0005, 0, '0);
    drive(0, '0, 0, '0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h0000_0005) begin
      errors++;
      $display("FAIL gap_l0: got v=%b d=%h want 1 00000005", valid_out, data_out);
    end
    drive(0, '0, 0, '0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h0000_0004) begin
      errors++;
      $display("FAIL gap_l1: got v=%b d=%h want 1 00000004", valid_out, data_out);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] seen[$];
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(0, '0, 1, 32'hAAAA_AAA0 + 32'(i));
      checks++;
      if (err_overflow !== (i == 5)) begin
        errors++;
        $display("FAIL ovf_flag push%0d: err=%b want %b", i, err_overflow, i == 5);
      end
    end
    for (int i = 0; i < 12; i++) begin
      if (i < 4) drive(1, 32'hB000_0000 + 32'(i), 0, '0);
      else       drive(0, '0, 0, '0);
      if (valid_out && data_out[31:28] == 4'hA) seen.push_back(data_out);
    end
    checks++;
    if (seen.size() != 4) begin
      errors++;
      $display("FAIL ovf_count: got %0d lane-1 words want 4", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 4; i++) begin
      checks++;
      if (seen[i] !== 32'hAAAA_AAA1 + 32'(i)) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h want %h", i, seen[i], 32'hAAAA_AAA1 + 32'(i));
      end
    end
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: err=%b want 1", err_overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 32'h5555_0000 + 32'(i));
    drive(0, '0, 1, 32'h5555_0003);
    drive(0, '0, 1, 32'h5555_0004);
    do_reset();
    checks++;
    if ({valid_out, err_overflow, data_out} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rmid_clear: got v=%b e=%b d=%h want 0 0 0", valid_out, err_overflow, data_out);
    end
    drive(1, 32'h0000_0003, 0, '0);
    drive(0, '0, 0, '0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h0000_0003) begin
      errors++;
      $display("FAIL rmid_first: got v=%b d=%h want 1 00000003", valid_out, data_out);
    end
    drive(0, '0, 0, '0);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rmid_flushed: valid_out=%b want 0 (stale lane-1 word)", valid_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      drive($urandom_range(0, 99) < 45, $urandom(),
            $urandom_range(0, 99) < 45, $urandom());
      checks++;
      if (valid_out !== mvalid || err_overflow !== merr || (mvalid && data_out !== mdata)) begin
        errors++;
        $display("FAIL random cyc%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 i, valid_out, err_overflow, data_out, mvalid, merr, mdata);
      end
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_no_skew();
    test_skew();
    test_gap();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
